serial_subtractor: RTL
======================

Name: serial_subtractor

Overview:
Bit-serial N-bit subtractor that computes A − B one bit per clock, LSB first.
- Each cycle it applies the single-bit difference/borrow relation (half-subtractor plus borrow-in, i.e. full-subtractor cell) and keeps the running borrow in a flip-flop.
- It is the sequential consumer stage for the single-bit subtractor cells: it chains the one-bit difference/borrow function across a word without replicating hardware per bit.
- Used wherever area matters more than latency.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range ≥ 1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  request to begin a subtraction; sampled only in IDLE.
- a  input  WIDTH  minuend; captured on the accepting edge.
- b  input  WIDTH  subtrahend; captured on the accepting edge.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; result valid.
- diff  output  WIDTH  (A − B) mod 2^WIDTH.
- borrow  output  1  final borrow-out; 1 iff A < B (unsigned).

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - state = IDLE.
  - busy, done, borrow = 0; diff = 0.
  - Internal shift registers, borrow flop and bit counter = 0.
- State machine: IDLE → RUN → DONE → IDLE. No other transitions.
- IDLE:
  - Edge with start = 1: load a_sh ← a, b_sh ← b, br ← 0, cnt ← 0, clear d_sh; go to RUN.
  - Edge with start = 0: stay in IDLE.
- RUN (one bit per edge, using LSBs a0 = a_sh[0], b0 = b_sh[0]):
  - d = a0 ^ b0 ^ br.
  - br_next = (~a0 & b0) | (~(a0 ^ b0) & br).
  - d_sh shifts right with d entering the MSB.
  - a_sh and b_sh shift right.
  - cnt increments.
  - On the edge where cnt == WIDTH−1: diff ← final assembled d_sh (including this bit), borrow ← br_next; go to DONE.
- DONE:
  - done = 1 for exactly one cycle.
  - Next edge → IDLE unconditionally.
- Latency:
  - start accepted at edge 0.
  - busy high from after edge 0 through edge WIDTH.
  - done high in the cycle after edge WIDTH.
  - Result visible on diff/borrow in that same cycle.
- Output hold:
  - diff and borrow are registered and updated only on RUN exit.
  - They hold their value through DONE, IDLE and the entire next RUN, until the next completion.
- start while busy or done is ignored; no queueing. a and b are don't-care outside the accepting edge.
- Back-to-back: start held high continuously gives one operation every WIDTH+2 cycles (IDLE acceptance, WIDTH RUN cycles, DONE).
- WIDTH = 1: cnt is 1 bit wide and RUN lasts one cycle. Behaves as a registered half subtractor: diff = a ^ b, borrow = ~a & b.
- Counter width: max(1, clog2(WIDTH)). No overflow is possible because exit occurs at WIDTH−1.
- Reset mid-RUN:
  - The operation is abandoned and done is never pulsed for it.
  - diff and borrow return to 0.
  - The next start after rst_n deasserts behaves as a fresh operation.

Test Plan:
- WIDTH = 8, a = 0x5A, b = 0x3C, start for 1 cycle → busy high 8 cycles, done pulse 1 cycle, diff = 0x1E, borrow = 0.
- WIDTH = 8, a = 0x3C, b = 0x5A → diff = 0xE2, borrow = 1. Also a = 0x00, b = 0x01 → diff = 0xFF, borrow = 1. Also a = 0xFF, b = 0xFF → diff = 0x00, borrow = 0.
- WIDTH = 1, all four (a, b) pairs 00/01/10/11 → (diff, borrow) = 00/11/10/00, done 2 cycles after acceptance.
- start re-asserted with different operands during RUN and during DONE → ignored; result matches the first operands; diff stays unchanged until the next completion.
- rst_n pulsed low at RUN cycle 4 of 8 → outputs 0 immediately (asynchronously), no done pulse. A new start then yields the correct result after the full latency.
- start tied high, 3 operand pairs → done pulses spaced WIDTH+2 = 10 cycles apart; each diff/borrow is correct against the reference model (a − b) mod 256, a < b.

Source files
------------

// File: rtl/serial_subtractor.sv
// Purpose : bit-serial unsigned subtractor, diff = (a - b) mod 2^WIDTH, LSB first, one bit per clock.
// Latency : start accepted at edge 0, done pulses in the cycle after edge WIDTH (one op every WIDTH+2 cycles).
// Backpres: none; start is only sampled in IDLE, requests while busy/done are dropped, no queueing.
//
// Ports:
//   clk, rst_n     clock (rising edge) and asynchronous active-low reset
//   start, a, b    operation request and operands (captured on the accepting edge)
//   busy           high while bits are being processed
//   done           one-cycle pulse when diff/borrow carry a new result
//   diff, borrow   registered result; held until the next completion
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] d_sh_q,   d_sh_d;
    logic             br_q,     br_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] diff_q,   diff_d;
    logic             borrow_q, borrow_d;
    logic             busy_q,   busy_d;
    logic             done_q,   done_d;

    // Full-subtractor cell on the current LSBs.
    logic             a0;
    logic             b0;
    logic             d_bit;
    logic             br_nxt;
    logic [WIDTH-1:0] d_sh_nxt;

    always_comb begin
        a0     = a_sh_q[0];
        b0     = b_sh_q[0];
        d_bit  = a0 ^ b0 ^ br_q;
        br_nxt = (~a0 & b0) | (~(a0 ^ b0) & br_q);

        // New difference bit enters at the MSB so that after WIDTH shifts
        // bit 0 of the result sits at position 0. Written as shift-then-set
        // so it also works for WIDTH == 1.
        d_sh_nxt            = d_sh_q >> 1;
        d_sh_nxt[WIDTH-1]   = d_bit;
    end

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        d_sh_d   = d_sh_q;
        br_d     = br_q;
        cnt_d    = cnt_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        busy_d   = busy_q;
        done_d   = done_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    d_sh_d  = '0;
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                d_sh_d = d_sh_nxt;
                br_d   = br_nxt;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    // Result registers only change here, so they hold
                    // through DONE, IDLE and the whole next RUN.
                    diff_d   = d_sh_nxt;
                    borrow_d = br_nxt;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                done_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                done_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            d_sh_q   <= '0;
            br_q     <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            d_sh_q   <= d_sh_d;
            br_q     <= br_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign diff   = diff_q;
    assign borrow = borrow_q;

endmodule
